// File: rtl/cgol_board_sequencer.sv
// Game of Life generation sequencer: streams 3x3 windows to cgol_cell, captures results, commits the board.
// Optional macro CGOL_DEAD_EDGE_EN: off-board neighbours read as dead instead of wrapping.
module cgol_board_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load_en,
  input  logic [$clog2(HEIGHT)-1:0]   i_load_addr,
  input  logic [WIDTH-1:0]            i_load_row,
  input  logic                        i_start,
  output logic [8:0]                  o_window,
  output logic                        o_window_valid,
  input  logic                        i_cell,
  output logic [WIDTH*HEIGHT-1:0]     o_board,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  idx_reg;
  logic [RW-1:0]  row_reg;
  logic [CW-1:0]  col_reg;
  logic [IW-1:0]  cap_idx_reg;
  logic           cap_valid_reg;
  logic [N-1:0]   next_reg;
  logic           done_reg;
  logic           last_cell;
  logic           idle_load;

  assign last_cell = (idx_reg == IW'(N - 1));
  assign idle_load = (state_reg == IDLE) && i_load_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A load in the same cycle as a start wins; the start is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start && !i_load_en) state_next = SCAN;
      SCAN:    if (last_cell) state_next = DRAIN;
      DRAIN:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (state_reg == SCAN) begin
      if (last_cell) begin
        idx_reg <= '0;
        row_reg <= '0;
        col_reg <= '0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
        if (col_reg == CW'(WIDTH - 1)) begin
          col_reg <= '0;
          row_reg <= row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  // cgol_cell is registered, so its result belongs to the index presented one cycle earlier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_valid_reg <= 1'b0;
      cap_idx_reg   <= '0;
      next_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      cap_valid_reg <= (state_reg == SCAN);
      cap_idx_reg   <= idx_reg;
      if (cap_valid_reg) next_reg[cap_idx_reg] <= i_cell;
      done_reg      <= (state_reg == COMMIT);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row
      logic [WIDTH-1:0] row_q;
      always_ff @(posedge clk) begin
        if (!rst_n)
          row_q <= '0;
        else if (state_reg == COMMIT)
          row_q <= next_reg[gi*WIDTH +: WIDTH];
        else if (idle_load && (i_load_addr == RW'(gi)))
          row_q <= i_load_row;
      end
      assign o_board[gi*WIDTH +: WIDTH] = row_q;
    end
  endgenerate

  function automatic logic bit_at(input logic [N-1:0] b, input logic [RW-1:0] r,
                                  input logic [CW-1:0] c);
    return b[IW'(r) * IW'(WIDTH) + IW'(c)];
  endfunction

  logic [RW-1:0] r_up, r_dn;
  logic [CW-1:0] c_lf, c_rt;
  logic          ok_up, ok_dn, ok_lf, ok_rt;
  logic [8:0]    win;

  always_comb begin
    r_up = (row_reg == '0) ? RW'(HEIGHT - 1) : row_reg - 1'b1;
    r_dn = (row_reg == RW'(HEIGHT - 1)) ? '0 : row_reg + 1'b1;
    c_lf = (col_reg == '0) ? CW'(WIDTH - 1) : col_reg - 1'b1;
    c_rt = (col_reg == CW'(WIDTH - 1)) ? '0 : col_reg + 1'b1;
`ifdef CGOL_DEAD_EDGE_EN
    ok_up = (row_reg != '0);
    ok_dn = (row_reg != RW'(HEIGHT - 1));
    ok_lf = (col_reg != '0);
    ok_rt = (col_reg != CW'(WIDTH - 1));
`else
    ok_up = 1'b1;
    ok_dn = 1'b1;
    ok_lf = 1'b1;
    ok_rt = 1'b1;
`endif
    win[0] = ok_up & ok_lf & bit_at(o_board, r_up,    c_lf);
    win[1] = ok_up &         bit_at(o_board, r_up,    col_reg);
    win[2] = ok_up & ok_rt & bit_at(o_board, r_up,    c_rt);
    win[3] = ok_lf &         bit_at(o_board, row_reg, c_lf);
    win[4] = ok_rt &         bit_at(o_board, row_reg, c_rt);
    win[5] =                 bit_at(o_board, row_reg, col_reg);
    win[6] = ok_dn & ok_lf & bit_at(o_board, r_dn,    c_lf);
    win[7] = ok_dn &         bit_at(o_board, r_dn,    col_reg);
    win[8] = ok_dn & ok_rt & bit_at(o_board, r_dn,    c_rt);
  end

  assign o_window       = (state_reg == SCAN) ? win : 9'd0;
  assign o_window_valid = (state_reg == SCAN);
  assign o_busy         = (state_reg != IDLE);
  assign o_done         = done_reg;

endmodule

// File: tb/tb_cgol_board_sequencer.sv
// Directed bench for cgol_board_sequencer with a behavioural registered cgol_cell.
// Expected boards are hand-computed Life patterns; build with CGOL_DEAD_EDGE_EN to check the dead-border variant.
module tb_cgol_board_sequencer;

  localparam logic [63:0] HORIZ = 64'h00000000_1C000000;
  localparam logic [63:0] VERT  = 64'h00000008_08080000;
  localparam logic [63:0] BLOCK = 64'h00000000_00000303;
  localparam logic [63:0] WRAPB = 64'h81000000_00000081;
`ifdef CGOL_DEAD_EDGE_EN
  localparam logic [63:0] WRAP_EXP = 64'h0;
  localparam logic [8:0]  WIN63    = 9'h000;
`else
  localparam logic [63:0] WRAP_EXP = WRAPB;
  localparam logic [8:0]  WIN63    = 9'h100;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_load_en = 1'b0;
  logic [2:0]  i_load_addr = '0;
  logic [7:0]  i_load_row = '0;
  logic        i_start = 1'b0;
  logic [8:0]  o_window;
  logic        o_window_valid;
  logic        i_cell = 1'b0;
  logic [63:0] o_board;
  logic        o_busy;
  logic        o_done;

  int compared = 0;
  int mismatched = 0;
  logic [8:0] win_log [64];
  int done_at, done_cnt, valid_cnt;

  always #5 clk = ~clk;

  cgol_board_sequencer #(.WIDTH(8), .HEIGHT(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_load_en(i_load_en), .i_load_addr(i_load_addr),
    .i_load_row(i_load_row), .i_start(i_start), .o_window(o_window),
    .o_window_valid(o_window_valid), .i_cell(i_cell), .o_board(o_board),
    .o_busy(o_busy), .o_done(o_done)
  );

  function automatic logic life(input logic [8:0] w);
    int n;
    n = $countones(w) - int'(w[5]);
    return w[5] ? (n == 2 || n == 3) : (n == 3);
  endfunction

  always @(posedge clk) i_cell <= life(o_window);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_board(input logic [63:0] b);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      i_load_en   = 1'b1;
      i_load_addr = 3'(r);
      i_load_row  = b[r*8 +: 8];
    end
    @(negedge clk);
    i_load_en = 1'b0;
    check("load", o_board, b);
  endtask

  // Cycle c is sampled 1 time unit after edge E0+c; perturbations are sampled at edge E0+at.
  task automatic run_gen(input int perturb_at, input int reset_at);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    done_at = -1; done_cnt = 0; valid_cnt = 0;
    for (int c = 0; c <= 90; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      i_start = 1'b0; i_load_en = 1'b0; rst_n = 1'b1;
      if (c < 64) win_log[c] = o_window;
      if (o_window_valid) valid_cnt++;
      if (o_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c + 1 == perturb_at) begin
        i_start = 1'b1; i_load_en = 1'b1; i_load_addr = 3'd0; i_load_row = 8'hFF;
      end
      if (c + 1 == reset_at) rst_n = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_board", o_board, 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    check("rst_valid", 64'(o_window_valid), 64'h0);
    check("rst_window", 64'(o_window), 64'h0);
    check("rst_done", 64'(o_done), 64'h0);
    rst_n = 1'b1;

    @(negedge clk);
    i_load_en = 1'b1; i_load_addr = 3'd5; i_load_row = 8'hA5; i_start = 1'b1;
    @(negedge clk);
    i_load_en = 1'b0; i_start = 1'b0;
    check("idle_conflict_load", o_board, 64'h0000A500_00000000);
    check("idle_conflict_busy", 64'(o_busy), 64'h0);

    load_board(HORIZ);
    run_gen(0, 0);
    check("blinker1_board", o_board, VERT);
    check("blinker1_done_at", 64'(done_at), 64'd66);
    check("blinker1_done_cnt", 64'(done_cnt), 64'd1);
    check("blinker1_valid_cnt", 64'(valid_cnt), 64'd64);
    check("blinker1_idle", 64'(o_busy), 64'h0);
    run_gen(0, 0);
    check("blinker2_board", o_board, HORIZ);
    check("blinker2_done_at", 64'(done_at), 64'd66);

    load_board(BLOCK);
    for (int g = 0; g < 5; g++) begin
      run_gen(0, 0);
      check("block_done_at", 64'(done_at), 64'd66);
    end
    check("block_board", o_board, BLOCK);

    load_board(WRAPB);
    run_gen(0, 0);
    check("wrap_block_board", o_board, WRAP_EXP);

    load_board(64'h1);
    run_gen(0, 0);
    check("single_win0", 64'(win_log[0]), 64'h020);
    check("single_win1", 64'(win_log[1]), 64'h008);
    check("single_win63", 64'(win_log[63]), 64'(WIN63));
    check("single_board", o_board, 64'h0);

    load_board(HORIZ);
    run_gen(0, 20);
    check("midrst_done_cnt", 64'(done_cnt), 64'd0);
    check("midrst_board", o_board, 64'h0);
    check("midrst_busy", 64'(o_busy), 64'h0);
    check("midrst_valid", 64'(o_window_valid), 64'h0);
    load_board(HORIZ);
    run_gen(0, 0);
    check("after_rst_board", o_board, VERT);
    check("after_rst_done_at", 64'(done_at), 64'd66);

    load_board(HORIZ);
    run_gen(10, 0);
    check("busy_perturb_board", o_board, VERT);
    check("busy_perturb_done_cnt", 64'(done_cnt), 64'd1);
    check("busy_perturb_done_at", 64'(done_at), 64'd66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
